// File: rtl/trace_slot_manager.sv
// trace_slot_manager
//   Owns a pool of fixed-size trace-packet slots in debug memory and runs their life cycle:
//   allocate -> filled by a DMA requester -> pushed to the ready queue -> released by the CPU.
//
// Ports
//   clk, rst                    clock; asynchronous active-high reset
//   req_valid / grant           per-requester slot request, one-hot 1-cycle grant pulse
//   alloc_addr                  granted slot address, meaningful only while grant != 0
//   done_valid / done_addr      per-requester completed packet and its slot address
//   done_ack                    one-hot 1-cycle pulse: completed entry taken
//   fifo_store_packet           push request to the ready queue
//   bus_initial_trace_address   address being pushed, stable while fifo_store_packet is high
//   address_ack                 ready queue accepted the push
//   release_valid/release_addr  CPU hands a slot back
//   release_err                 1-cycle pulse: release rejected
//   free_count                  number of free slots
module trace_slot_manager #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned NUM_SLOTS     = 16,
    parameter int unsigned SLOT_BYTES    = 64,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [ADDRESS_WIDTH-1:0]           alloc_addr,
    input  logic [NUM_REQ-1:0]                 done_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   done_addr,
    output logic [NUM_REQ-1:0]                 done_ack,
    output logic                               fifo_store_packet,
    output logic [ADDRESS_WIDTH-1:0]           bus_initial_trace_address,
    input  logic                               address_ack,
    input  logic                               release_valid,
    input  logic [ADDRESS_WIDTH-1:0]           release_addr,
    output logic                               release_err,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     free_count
);

    localparam int unsigned CNT_W    = $clog2(NUM_SLOTS + 1);
    localparam int unsigned SLOT_IW  = $clog2(NUM_SLOTS);
    localparam int unsigned REQ_IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned OFF_BITS = $clog2(SLOT_BYTES);
    localparam int unsigned AW1      = ADDRESS_WIDTH + 1;

    localparam logic [ADDRESS_WIDTH:0]   SPAN     = AW1'(NUM_SLOTS * SLOT_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK = ADDRESS_WIDTH'(SLOT_BYTES - 1);
    localparam logic [REQ_IW-1:0]        LAST_REQ = REQ_IW'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StPush} push_state_e;

    // State
    logic [NUM_SLOTS-1:0]     used_q, used_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [ADDRESS_WIDTH-1:0] alloc_addr_q, alloc_addr_d;
    logic [REQ_IW-1:0]        alloc_ptr_q, alloc_ptr_d;
    push_state_e              state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] push_addr_q, push_addr_d;
    logic [NUM_REQ-1:0]       done_ack_q, done_ack_d;
    logic [REQ_IW-1:0]        done_ptr_q, done_ptr_d;
    logic                     release_err_q, release_err_d;

    // Allocation decode
    logic [NUM_REQ-1:0] req_eligible;
    logic [REQ_IW-1:0]  alloc_cand;
    logic [REQ_IW-1:0]  alloc_req;
    logic               alloc_found;
    logic [SLOT_IW-1:0] slot_idx;
    logic               slot_found;
    logic               alloc_valid;

    // Push decode
    logic [REQ_IW-1:0]        done_cand;
    logic [REQ_IW-1:0]        done_sel;
    logic                     done_found;
    logic [ADDRESS_WIDTH-1:0] done_sel_addr;

    // Release decode
    logic [ADDRESS_WIDTH:0]   rel_diff;
    logic [ADDRESS_WIDTH-1:0] rel_off;
    logic [SLOT_IW-1:0]       rel_idx;
    logic                     rel_ok;

    logic [CNT_W-1:0] free_cnt;

    // Round-robin requester pick, then lowest-index free slot. A requester being granted this
    // cycle is masked so a req_valid still high during its grant pulse is not double-served.
    always_comb begin
        req_eligible = req_valid & ~grant_q;
        alloc_found  = 1'b0;
        alloc_req    = alloc_ptr_q;
        alloc_cand   = alloc_ptr_q;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            alloc_cand = REQ_IW'((int'(alloc_ptr_q) + k) % int'(NUM_REQ));
            if (!alloc_found && req_eligible[alloc_cand]) begin
                alloc_found = 1'b1;
                alloc_req   = alloc_cand;
            end
        end

        slot_found = 1'b0;
        slot_idx   = '0;
        for (int s = int'(NUM_SLOTS) - 1; s >= 0; s--) begin
            if (!used_q[s]) begin
                slot_found = 1'b1;
                slot_idx   = SLOT_IW'(s);
            end
        end

        alloc_valid = alloc_found && slot_found;
    end

    // Release check. The extra top bit of rel_diff is the borrow, i.e. address below the base.
    always_comb begin
        rel_diff = {1'b0, release_addr} - {1'b0, BASE_ADDR};
        rel_off  = rel_diff[ADDRESS_WIDTH-1:0];
        rel_idx  = SLOT_IW'(rel_off >> OFF_BITS);
        rel_ok   = release_valid
                   && !rel_diff[ADDRESS_WIDTH]
                   && ({1'b0, rel_off} < SPAN)
                   && ((rel_off & OFF_MASK) == '0)
                   && used_q[rel_idx];
        release_err_d = release_valid && !rel_ok;
    end

    // Slot bookkeeping: a slot being released is still marked used this cycle, so it can
    // never collide with the slot chosen by the allocator in the same edge.
    always_comb begin
        used_d       = used_q;
        grant_d      = '0;
        alloc_addr_d = alloc_addr_q;
        alloc_ptr_d  = alloc_ptr_q;
        if (alloc_valid) begin
            used_d[slot_idx]   = 1'b1;
            grant_d[alloc_req] = 1'b1;
            alloc_addr_d       = BASE_ADDR + (ADDRESS_WIDTH'(slot_idx) << OFF_BITS);
            alloc_ptr_d        = alloc_req;
        end
        if (rel_ok) begin
            used_d[rel_idx] = 1'b0;
        end
    end

    // Push FSM next state
    always_comb begin
        done_found    = 1'b0;
        done_sel      = done_ptr_q;
        done_cand     = done_ptr_q;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            done_cand = REQ_IW'((int'(done_ptr_q) + k) % int'(NUM_REQ));
            if (!done_found && done_valid[done_cand]) begin
                done_found = 1'b1;
                done_sel   = done_cand;
            end
        end
        done_sel_addr = '0;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            if (REQ_IW'(r) == done_sel) begin
                done_sel_addr = done_addr[r*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end

        state_d     = state_q;
        push_addr_d = push_addr_q;
        done_ack_d  = '0;
        done_ptr_d  = done_ptr_q;
        case (state_q)
            StIdle: begin
                if (done_found) begin
                    push_addr_d          = done_sel_addr;
                    done_ack_d[done_sel] = 1'b1;
                    done_ptr_d           = done_sel;
                    state_d              = StPush;
                end
            end
            StPush: begin
                if (address_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        free_cnt = '0;
        for (int s = 0; s < int'(NUM_SLOTS); s++) begin
            free_cnt = free_cnt + CNT_W'(!used_q[s]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used_q        <= '0;
            grant_q       <= '0;
            alloc_addr_q  <= '0;
            alloc_ptr_q   <= LAST_REQ;
            state_q       <= StIdle;
            push_addr_q   <= '0;
            done_ack_q    <= '0;
            done_ptr_q    <= LAST_REQ;
            release_err_q <= 1'b0;
        end else begin
            used_q        <= used_d;
            grant_q       <= grant_d;
            alloc_addr_q  <= alloc_addr_d;
            alloc_ptr_q   <= alloc_ptr_d;
            state_q       <= state_d;
            push_addr_q   <= push_addr_d;
            done_ack_q    <= done_ack_d;
            done_ptr_q    <= done_ptr_d;
            release_err_q <= release_err_d;
        end
    end

    assign grant                     = grant_q;
    assign alloc_addr                = alloc_addr_q;
    assign done_ack                  = done_ack_q;
    assign fifo_store_packet         = (state_q == StPush);
    assign bus_initial_trace_address = push_addr_q;
    assign release_err               = release_err_q;
    assign free_count                = free_cnt;

endmodule

// File: tb/tb_trace_slot_manager.sv
// Bench for trace_slot_manager: directed scenarios followed by random traffic, all checked
// cycle by cycle against a slot-pool model built from sets and round-robin counters.
module tb_trace_slot_manager;

    localparam int AW = 32;
    localparam int NR = 2;
    localparam int NS = 16;
    localparam int SB = 64;
    localparam logic [31:0] BASE = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] grant;
    logic [AW-1:0] alloc_addr;
    logic [NR-1:0] done_valid;
    logic [NR*AW-1:0] done_addr;
    logic [NR-1:0] done_ack;
    logic          fifo_store_packet;
    logic [AW-1:0] bus_initial_trace_address;
    logic          address_ack;
    logic          release_valid;
    logic [AW-1:0] release_addr;
    logic          release_err;
    logic [4:0]    free_count;

    always #5 clk = ~clk;

    trace_slot_manager #(
        .ADDRESS_WIDTH(AW),
        .NUM_REQ      (NR),
        .NUM_SLOTS    (NS),
        .SLOT_BYTES   (SB),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .req_valid                (req_valid),
        .grant                    (grant),
        .alloc_addr               (alloc_addr),
        .done_valid               (done_valid),
        .done_addr                (done_addr),
        .done_ack                 (done_ack),
        .fifo_store_packet        (fifo_store_packet),
        .bus_initial_trace_address(bus_initial_trace_address),
        .address_ack              (address_ack),
        .release_valid            (release_valid),
        .release_addr             (release_addr),
        .release_err              (release_err),
        .free_count               (free_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    bit          m_free [NS];
    int          m_last_alloc;
    int          m_last_done;
    logic [NR-1:0] m_grant;
    logic [31:0] m_alloc_addr;
    logic [NR-1:0] m_done_ack;
    bit          m_busy;
    logic [31:0] m_addr;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_free_count();
        int n = 0;
        for (int s = 0; s < NS; s++) n += m_free[s] ? 1 : 0;
        return n;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) m_free[s] = 1'b1;
        m_last_alloc = NR - 1;
        m_last_done  = NR - 1;
        m_grant      = '0;
        m_alloc_addr = '0;
        m_done_ack   = '0;
        m_busy       = 1'b0;
        m_addr       = '0;
        m_err        = 1'b0;
    endtask

    task automatic compare_all();
        check("grant", 32'(grant), 32'(m_grant));
        if (m_grant != '0) check("alloc_addr", alloc_addr, m_alloc_addr);
        check("done_ack", 32'(done_ack), 32'(m_done_ack));
        check("fifo_store_packet", 32'(fifo_store_packet), 32'(m_busy));
        check("bus_address", bus_initial_trace_address, m_addr);
        check("release_err", 32'(release_err), 32'(m_err));
        check("free_count", 32'(free_count), 32'(m_free_count()));
    endtask

    // One clock: predict from the current inputs, advance, then compare.
    task automatic step();
        logic [NR-1:0] n_grant = '0;
        logic [31:0]   n_alloc = m_alloc_addr;
        int            n_last_alloc = m_last_alloc;
        int            take = -1;
        int            lowest = -1;
        int            rel_slot = -1;
        bit            n_err = 1'b0;
        logic [NR-1:0] n_ack = '0;
        bit            n_busy = m_busy;
        logic [31:0]   n_addr = m_addr;
        int            n_last_done = m_last_done;
        longint        ra;

        for (int s = NS - 1; s >= 0; s--) if (m_free[s]) lowest = s;
        if (lowest >= 0) begin
            for (int k = 1; k <= NR; k++) begin
                int r = (m_last_alloc + k) % NR;
                if (n_grant == '0 && req_valid[r] && !m_grant[r]) begin
                    n_grant[r]   = 1'b1;
                    n_alloc      = BASE + 32'(lowest * SB);
                    n_last_alloc = r;
                    take         = lowest;
                end
            end
        end

        if (release_valid) begin
            ra = longint'(release_addr) - longint'(BASE);
            if (ra < 0 || ra >= NS * SB || (ra % SB) != 0) n_err = 1'b1;
            else if (m_free[int'(ra / SB)]) n_err = 1'b1;
            else rel_slot = int'(ra / SB);
        end

        if (!m_busy) begin
            for (int k = 1; k <= NR; k++) begin
                int r = (m_last_done + k) % NR;
                if (!n_busy && done_valid[r]) begin
                    n_busy      = 1'b1;
                    n_addr      = done_addr[r*AW +: AW];
                    n_ack[r]    = 1'b1;
                    n_last_done = r;
                end
            end
        end else if (address_ack) begin
            n_busy = 1'b0;
        end

        @(posedge clk);
        #1;
        if (take >= 0) m_free[take] = 1'b0;
        if (rel_slot >= 0) m_free[rel_slot] = 1'b1;
        m_grant      = n_grant;
        m_alloc_addr = n_alloc;
        m_last_alloc = n_last_alloc;
        m_err        = n_err;
        m_done_ack   = n_ack;
        m_busy       = n_busy;
        m_addr       = n_addr;
        m_last_done  = n_last_done;
        compare_all();
    endtask

    task automatic clear_inputs();
        req_valid     = '0;
        done_valid    = '0;
        done_addr     = '0;
        address_ack   = 1'b0;
        release_valid = 1'b0;
        release_addr  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        int ack_pulses;
        int slot;

        // Reset and first allocations
        do_reset();
        check("reset_free_count", 32'(free_count), NS);
        req_valid = 2'b01;
        step();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_addr0", alloc_addr, 32'h00);
        check("t1_free", 32'(free_count), 15);
        req_valid = 2'b00;
        step();
        req_valid = 2'b01;
        step();
        check("t1_addr1", alloc_addr, 32'h40);
        req_valid = 2'b00;

        // Alternating grants until the pool is empty
        do_reset();
        req_valid = 2'b11;
        for (int i = 0; i < NS; i++) begin
            step();
            check("t2_alternate", 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        step();
        check("t2_empty_grant", 32'(grant), 32'h0);
        check("t2_empty_free", 32'(free_count), 0);

        // Release into an empty pool while both requesters wait
        release_valid = 1'b1;
        release_addr  = 32'h3C0;
        step();
        check("t4_free_after_release", 32'(free_count), 1);
        release_valid = 1'b0;
        step();
        check("t4_regrant", 32'(grant), 32'h1);
        check("t4_regrant_addr", alloc_addr, 32'h3C0);
        req_valid = 2'b00;
        step();

        // Invalid releases
        release_valid = 1'b1;
        release_addr  = 32'h44;
        step();
        check("t5_misaligned", 32'(release_err), 1);
        release_addr = 32'h400;
        step();
        check("t5_out_of_range", 32'(release_err), 1);
        check("t5_free_same", 32'(free_count), 0);
        release_addr = 32'h0;
        step();
        check("t5_valid_release", 32'(release_err), 0);
        step();
        check("t5_double_release", 32'(release_err), 1);
        check("t5_free_one", 32'(free_count), 1);
        release_valid = 1'b0;

        // Push with back-pressure
        ack_pulses = 0;
        done_valid = 2'b01;
        done_addr[0 +: AW] = 32'h80;
        step();
        ack_pulses += done_ack[0] ? 1 : 0;
        check("t3_store", 32'(fifo_store_packet), 1);
        done_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            ack_pulses += done_ack[0] ? 1 : 0;
            check("t3_stable", bus_initial_trace_address, 32'h80);
        end
        address_ack = 1'b1;
        step();
        ack_pulses += done_ack[0] ? 1 : 0;
        address_ack = 1'b0;
        check("t3_idle", 32'(fifo_store_packet), 0);
        check("t3_ack_once", 32'(ack_pulses), 1);

        // Reset in the middle of a push
        do_reset();
        req_valid = 2'b11;
        repeat (3) step();
        req_valid = 2'b00;
        done_valid = 2'b10;
        done_addr[AW +: AW] = 32'h40;
        step();
        check("t6_pushing", 32'(fifo_store_packet), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_store_cleared", 32'(fifo_store_packet), 0);
        check("t6_free_full", 32'(free_count), NS);
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b01;
        step();
        check("t6_first_addr", alloc_addr, 32'h00);
        req_valid = 2'b00;

        // Random traffic
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (m_grant[i]) req_valid[i] = ($urandom % 4 == 0);
                else if (!req_valid[i]) req_valid[i] = ($urandom % 3 == 0);
                if (m_done_ack[i]) done_valid[i] = 1'b0;
                else if (!done_valid[i] && ($urandom % 5 == 0)) begin
                    done_valid[i] = 1'b1;
                    done_addr[i*AW +: AW] = BASE + 32'($urandom_range(0, NS - 1) * SB);
                end
            end
            address_ack   = ($urandom % 3 == 0);
            release_valid = ($urandom % 3 == 0);
            slot = int'($urandom_range(0, NS - 1));
            case ($urandom % 8)
                0: release_addr = $urandom;
                1: release_addr = BASE + 32'(slot * SB + int'($urandom_range(1, SB - 1)));
                2: release_addr = BASE + 32'(NS * SB + slot * SB);
                default: release_addr = BASE + 32'(slot * SB);
            endcase
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
